// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_ctrl_pkg
// Description : Shared definitions for the convolution control path.
//               Contains the sequencer state encoding and its error codes.
// Revision    : 1.0  initial release
// ============================================================================
package conv_ctrl_pkg;

  // Sequencer state encoding (3-bit).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } seq_state_e;

  // Error codes reported on err_code_o.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_LENGTH   = 2'b10;
  localparam logic [1:0] ERR_PROTOCOL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer_if
// Description : Start/run/done handshake between the sequencer and a
//               fixed-length worker.
//   wk_start_o : sequencer -> worker, one-cycle start pulse
//   wk_run_i   : worker -> sequencer, one cycle per unit of work
//   wk_done_i  : worker -> sequencer, end-of-run pulse
// Revision    : 1.0  initial release
// ============================================================================
interface run_sequencer_if;
  logic wk_start_o;
  logic wk_run_i;
  logic wk_done_i;

  modport master (output wk_start_o, input wk_run_i, input wk_done_i);
  modport slave  (input wk_start_o, output wk_run_i, output wk_done_i);
endinterface
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Clearable cycle counter with terminal-count flag. Counts while
//               en_i is high and stops at TIMEOUT_CYC-1 (never wraps).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (priority over en_i)
//   en_i       : count enable
//   tc_o       : count has reached TIMEOUT_CYC-1
// Revision    : 1.0  initial release
// ============================================================================
module seq_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (en_i && cnt_q != TC_VAL) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer
// Description : Multi-pass controller for a fixed-length worker. Issues one
//               start pulse per pass, checks run length and timeout on each
//               pass, and reports completion or a sticky error.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : command pulse (accepted in IDLE only)
//   num_pass_i  : number of passes, latched with start_i
//   clr_i       : leaves ERR (accepted in ERR only)
//   busy_o      : in ISSUE, WAIT or NEXT
//   done_o      : one-cycle completion pulse
//   err_o       : sticky error flag
//   err_code_o  : 01 timeout, 10 length mismatch, 11 protocol violation
//   pass_idx_o  : index of the current pass
//   wk          : worker handshake (master side)
// Revision    : 1.0  initial release
// ============================================================================
module run_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int COUNT_NUM   = 4,
  parameter int PASS_MAX    = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [$clog2(PASS_MAX+1)-1:0] num_pass_i,
  input  logic                          clr_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [1:0]                    err_code_o,
  output logic [$clog2(PASS_MAX)-1:0]   pass_idx_o,
  run_sequencer_if.master               wk
);
  localparam int NPW = $clog2(PASS_MAX + 1);
  localparam int PIW = $clog2(PASS_MAX);
  localparam int RCW = $clog2(COUNT_NUM + 2);
  localparam logic [RCW-1:0] RUN_OK  = RCW'(COUNT_NUM);
  localparam logic [RCW-1:0] RUN_SAT = RCW'(COUNT_NUM + 1);

  seq_state_e     state_q, state_d;
  logic [NPW-1:0] num_pass_q, num_pass_d;
  logic [PIW-1:0] pass_idx_q, pass_idx_d;
  logic [RCW-1:0] run_cnt_q, run_cnt_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           wdog_clr, wdog_en, wdog_tc;
  logic           last_pass;

  seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (wdog_clr),
    .en_i  (wdog_en),
    .tc_o  (wdog_tc)
  );

  assign last_pass = ((NPW'(pass_idx_q) + NPW'(1)) == num_pass_q);

  always_comb begin
    state_d    = state_q;
    num_pass_d = num_pass_q;
    pass_idx_d = pass_idx_q;
    run_cnt_d  = run_cnt_q;
    err_code_d = err_code_q;
    wdog_clr   = 1'b0;
    wdog_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_pass_d = num_pass_i;
          pass_idx_d = '0;
          state_d    = (num_pass_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        run_cnt_d = '0;
        wdog_clr  = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        wdog_en = 1'b1;
        if (wk.wk_run_i && run_cnt_q != RUN_SAT) run_cnt_d = run_cnt_q + RCW'(1);
        // Decisions use the count of completed run cycles (run_cnt_q); a run
        // coincident with done is a protocol error regardless of the count.
        if (wk.wk_run_i && wk.wk_done_i) begin
          err_code_d = ERR_PROTOCOL;
          state_d    = S_ERR;
        end else if (wk.wk_done_i) begin
          if (run_cnt_q == RUN_OK) begin
            state_d = last_pass ? S_DONE : S_NEXT;
          end else begin
            err_code_d = ERR_LENGTH;
            state_d    = S_ERR;
          end
        end else if (wdog_tc) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end
      end
      S_NEXT: begin
        pass_idx_d = pass_idx_q + PIW'(1);
        state_d    = S_ISSUE;
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (clr_i) begin
          err_code_d = ERR_NONE;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_pass_q <= '0;
      pass_idx_q <= '0;
      run_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      num_pass_q <= num_pass_d;
      pass_idx_q <= pass_idx_d;
      run_cnt_q  <= run_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Moore outputs: pure decodes of registered state.
  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERR);
  assign err_code_o    = err_code_q;
  assign pass_idx_o    = pass_idx_q;
  assign wk.wk_start_o = (state_q == S_ISSUE);

endmodule
`default_nettype wire
